// File: rtl/scnn_pkg.sv
// Shared constants, index-vector types and sequencer state encoding for the
// SCNN output-coordinate scheduler.
package scnn_pkg;

    localparam int VEC      = 4;
    localparam int WT_IDX_W = 4;
    localparam int IP_IDX_W = 5;
    localparam int ADDR_W   = 4;

    typedef logic [VEC-1:0][WT_IDX_W-1:0] wt_vec_t;
    typedef logic [VEC-1:0][IP_IDX_W-1:0] ip_vec_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_CAP   = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RD    = ST_RD,
        CAP   = ST_CAP,
        VALID = ST_VALID,
        FIN   = ST_FIN
    } sched_state_e;

endpackage

// File: rtl/scnn_chunk_ctr.sv
// Chunk index counter: walks 0..count-1 and flags the final chunk.
module scnn_chunk_ctr
    import scnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] count,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] value,
    output logic              is_last
);

    logic [ADDR_W-1:0] limit;

    // count is nonzero whenever the sweep is using this counter
    assign limit   = count - ADDR_W'(1);
    assign is_last = (value == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= value + ADDR_W'(1);
    end

endmodule

// File: rtl/scnn_cordn_sched.sv
// Sequencer for the SCNN output-coordinate unit: weight-major sweep over
// weight x input chunk pairs. Optional counters under SCNN_SCHED_PERF_EN.
module scnn_cordn_sched
    import scnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   num_wt_chunks,
    input  logic [ADDR_W-1:0]   num_ip_chunks,
    output logic                wt_rd_en,
    output logic [ADDR_W-1:0]   wt_addr,
    input  wt_vec_t             wt_rdata,
    output logic                ip_rd_en,
    output logic [ADDR_W-1:0]   ip_addr,
    input  ip_vec_t             ip_rdata,
    output wt_vec_t             comp_wt_ind,
    output ip_vec_t             comp_ip_ind,
    output logic [WT_IDX_W-1:0] offset_wt,
    output logic [IP_IDX_W-1:0] offset_ip,
    input  logic [WT_IDX_W-1:0] last_ind_wts,
    input  logic [IP_IDX_W-1:0] last_ind_ips,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         stall_cycles,
    output logic [15:0]         pair_count
);

    sched_state_e        state;
    logic [ADDR_W-1:0]   num_wt;
    logic [ADDR_W-1:0]   num_ip;
    logic [WT_IDX_W-1:0] last_wt;
    logic                wt_read;
    logic                accept;
    logic                cnt_zero;
    logic                hs;
    logic                wt_inc;
    logic                ip_inc;
    logic                ip_clr;
    logic                wt_is_last;
    logic                ip_is_last;
    logic                ip_first;

    assign accept    = (state == IDLE) && start;
    assign cnt_zero  = (num_wt_chunks == '0) || (num_ip_chunks == '0);
    assign hs        = (state == VALID) && out_ready;
    assign ip_inc    = hs && !ip_is_last;
    assign wt_inc    = hs && ip_is_last && !wt_is_last;
    assign ip_clr    = accept || wt_inc;
    assign ip_first  = (ip_addr == '0);

    assign out_valid = (state == VALID);
    assign busy      = (state == RD) || (state == CAP) || (state == VALID);
    assign done      = (state == FIN);

    scnn_chunk_ctr u_wt_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (num_wt),
        .inc     (wt_inc),
        .clr     (accept),
        .value   (wt_addr),
        .is_last (wt_is_last)
    );

    scnn_chunk_ctr u_ip_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (num_ip),
        .inc     (ip_inc),
        .clr     (ip_clr),
        .value   (ip_addr),
        .is_last (ip_is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_wt      <= '0;
            num_ip      <= '0;
            wt_rd_en    <= 1'b0;
            ip_rd_en    <= 1'b0;
            wt_read     <= 1'b0;
            comp_wt_ind <= '0;
            comp_ip_ind <= '0;
            offset_wt   <= '0;
            offset_ip   <= '0;
            last_wt     <= '0;
        end else begin
            wt_rd_en <= 1'b0;
            ip_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cnt_zero) begin
                            state <= FIN;
                        end else begin
                            num_wt    <= num_wt_chunks;
                            num_ip    <= num_ip_chunks;
                            offset_wt <= '0;
                            offset_ip <= '0;
                            wt_rd_en  <= 1'b1;
                            ip_rd_en  <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    wt_read <= wt_rd_en;
                    state   <= CAP;
                end
                CAP: begin
                    // the weight buffer output is only meaningful after a weight read
                    if (wt_read)
                        comp_wt_ind <= wt_rdata;
                    comp_ip_ind <= ip_rdata;
                    state       <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        if (ip_first)
                            last_wt <= last_ind_wts;
                        if (!ip_is_last) begin
                            offset_ip <= last_ind_ips + IP_IDX_W'(1);
                            ip_rd_en  <= 1'b1;
                            state     <= RD;
                        end else if (!wt_is_last) begin
                            // single-input sweeps finish the weight chunk on its first handshake
                            offset_wt <= (ip_first ? last_ind_wts : last_wt) + WT_IDX_W'(1);
                            offset_ip <= '0;
                            wt_rd_en  <= 1'b1;
                            ip_rd_en  <= 1'b1;
                            state     <= RD;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCNN_SCHED_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] pair_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            pair_q  <= '0;
        end else if (accept) begin
            stall_q <= '0;
            pair_q  <= '0;
        end else begin
            if ((state == VALID) && !out_ready)
                stall_q <= stall_q + 16'd1;
            if (hs)
                pair_q <= pair_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign pair_count   = pair_q;
`else
    assign stall_cycles = '0;
    assign pair_count   = '0;
`endif

endmodule

// File: tb/tb_scnn_cordn_sched.sv
// Self-checking bench for scnn_cordn_sched: sweep-level model of expected beats,
// per-cycle comparison, plus literal expectations for key offsets and timing.
module tb_scnn_cordn_sched;
    import scnn_pkg::*;

    localparam int BW = 2*ADDR_W + WT_IDX_W + IP_IDX_W + VEC*(WT_IDX_W + IP_IDX_W);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   num_wt_chunks = '0;
    logic [ADDR_W-1:0]   num_ip_chunks = '0;
    logic                wt_rd_en;
    logic [ADDR_W-1:0]   wt_addr;
    wt_vec_t             wt_rdata;
    logic                ip_rd_en;
    logic [ADDR_W-1:0]   ip_addr;
    ip_vec_t             ip_rdata;
    wt_vec_t             comp_wt_ind;
    ip_vec_t             comp_ip_ind;
    logic [WT_IDX_W-1:0] offset_wt;
    logic [IP_IDX_W-1:0] offset_ip;
    logic [WT_IDX_W-1:0] last_ind_wts = '0;
    logic [IP_IDX_W-1:0] last_ind_ips = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                busy;
    logic                done;
    logic [15:0]         stall_cycles;
    logic [15:0]         pair_count;

    always #5 clk = ~clk;

    scnn_cordn_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_wt_chunks (num_wt_chunks),
        .num_ip_chunks (num_ip_chunks),
        .wt_rd_en      (wt_rd_en),
        .wt_addr       (wt_addr),
        .wt_rdata      (wt_rdata),
        .ip_rd_en      (ip_rd_en),
        .ip_addr       (ip_addr),
        .ip_rdata      (ip_rdata),
        .comp_wt_ind   (comp_wt_ind),
        .comp_ip_ind   (comp_ip_ind),
        .offset_wt     (offset_wt),
        .offset_ip     (offset_ip),
        .last_ind_wts  (last_ind_wts),
        .last_ind_ips  (last_ind_ips),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .stall_cycles  (stall_cycles),
        .pair_count    (pair_count)
    );

    // Index buffers: one-cycle read latency, junk on the bus when not read.
    wt_vec_t wmem [16];
    ip_vec_t imem [16];

    always @(posedge clk) begin
        wt_rdata <= wt_rd_en ? wmem[wt_addr] : wt_vec_t'($urandom);
        ip_rdata <= ip_rd_en ? imem[ip_addr] : ip_vec_t'($urandom);
    end

    int errors = 0;
    int checks = 0;

    // Sweep model: W x I beats, coordinate-unit replies are a function of beat number.
    int m_w, m_i, m_lw, m_lp;
    int hs_cnt, wt_reads, ip_reads;
    logic [WT_IDX_W-1:0] obs_owt [64];
    logic [IP_IDX_W-1:0] obs_oip [64];

    function automatic logic [WT_IDX_W-1:0] lwt_at(input int k);
        return WT_IDX_W'((m_lw + 5*k) % 16);
    endfunction

    function automatic logic [IP_IDX_W-1:0] lip_at(input int k);
        return IP_IDX_W'((m_lp + 3*k) % 32);
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int k);
        int w;
        int i;
        logic [WT_IDX_W-1:0] ow;
        logic [IP_IDX_W-1:0] oi;
        w  = k / m_i;
        i  = k % m_i;
        ow = (w == 0) ? '0 : WT_IDX_W'((int'(lwt_at((w-1)*m_i)) + 1) % 16);
        oi = (i == 0) ? '0 : IP_IDX_W'((int'(lip_at(k-1)) + 1) % 32);
        return {wmem[w], imem[i], ow, oi, ADDR_W'(w), ADDR_W'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [BW-1:0] act;
        if (wt_rd_en) wt_reads++;
        if (ip_rd_en) ip_reads++;
        if (out_valid) begin
            chk("beat_in_range", 64'(hs_cnt < m_w*m_i), 64'd1);
            if (hs_cnt < m_w*m_i) begin
                act = {comp_wt_ind, comp_ip_ind, offset_wt, offset_ip, wt_addr, ip_addr};
                obs_owt[hs_cnt] = offset_wt;
                obs_oip[hs_cnt] = offset_ip;
                chk($sformatf("beat%0d", hs_cnt), 64'(act), 64'(exp_beat(hs_cnt)));
            end
            if (out_ready) hs_cnt++;
        end
    endtask

    // sb/sl: stall beat and length; sa: cycle to pulse a stray start; ab: beat at which to reset
    task automatic sweep(input int w, input int i, input int lw, input int lp,
                         input int sb, input int sl, input int sa, input int ab);
        int cyc;
        int first_v;
        int stl_left;
        int exp_cyc;
        bit fin;
        m_w = w; m_i = i; m_lw = lw; m_lp = lp;
        hs_cnt = 0; wt_reads = 0; ip_reads = 0;
        last_ind_wts  = lwt_at(0);
        last_ind_ips  = lip_at(0);
        out_ready     = 1'b1;
        num_wt_chunks = ADDR_W'(w);
        num_ip_chunks = ADDR_W'(i);
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        num_wt_chunks = '1;
        num_ip_chunks = '1;
        cyc = 1; first_v = 0; stl_left = sl; fin = 0;
        while (cyc < 300) begin
            last_ind_wts = lwt_at(hs_cnt);
            last_ind_ips = lip_at(hs_cnt);
            if (out_valid && hs_cnt == sb && stl_left > 0) begin
                out_ready = 1'b0;
                stl_left--;
            end else begin
                out_ready = 1'b1;
            end
            start = (cyc == sa);
            if (out_valid && first_v == 0) first_v = cyc;
            if (done) begin
                fin = 1;
                break;
            end
            if (ab >= 0 && out_valid && hs_cnt == ab) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("reset_mid_outputs",
                    64'({out_valid, busy, done, wt_rd_en, ip_rd_en, offset_wt, offset_ip, wt_addr, ip_addr}),
                    64'd0);
                chk("reset_mid_comp", 64'({comp_wt_ind, comp_ip_ind}), 64'd0);
                start = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("reset_no_done", 64'(done), 64'd0);
                end
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("after_reset_idle", 64'({done, busy, out_valid}), 64'd0);
                return;
            end
            @(negedge clk);
            compare();
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        exp_cyc = (w == 0 || i == 0) ? 1 : 3*w*i + 1 + sl;
        chk("done_cycle", fin ? 64'(cyc) : 64'hDEAD, 64'(exp_cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("first_valid_cycle", 64'(first_v), (w == 0 || i == 0) ? 64'd0 : 64'd3);
        chk("pairs", 64'(hs_cnt), 64'(w*i));
        chk("wt_reads", 64'(wt_reads), (w == 0 || i == 0) ? 64'd0 : 64'(w));
        chk("ip_reads", 64'(ip_reads), 64'(w*i));
        @(posedge clk); #1;
        chk("done_one_cycle", 64'({done, busy, out_valid}), 64'd0);
`ifdef SCNN_SCHED_PERF_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(sl));
        chk("pair_count", 64'(pair_count), 64'(w*i));
`else
        chk("stall_cycles_off", 64'(stall_cycles), 64'd0);
        chk("pair_count_off", 64'(pair_count), 64'd0);
`endif
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            wmem[k] = '0;
            imem[k] = '0;
        end
        #1;
        chk("reset_state",
            64'({out_valid, busy, done, wt_rd_en, ip_rd_en, offset_wt, offset_ip, wt_addr, ip_addr,
                 stall_cycles, pair_count}),
            64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1x1 with zero index data
        sweep(1, 1, 0, 0, -1, 0, -1, -1);
        chk("t1_offsets", 64'({obs_owt[0], obs_oip[0]}), 64'd0);

        for (int k = 0; k < 16; k++) begin
            wmem[k] = wt_vec_t'($urandom);
            imem[k] = ip_vec_t'($urandom);
        end

        // 1x2: second beat offset follows last_ind_ips=3
        sweep(1, 2, 2, 3, -1, 0, -1, -1);
        chk("t2_oip_beat1", 64'(obs_oip[1]), 64'd4);

        // 2x2 with a stray start while busy
        sweep(2, 2, 6, 10, -1, 0, 5, -1);
        chk("t3_owt_beat2", 64'(obs_owt[2]), 64'd7);
        chk("t3_oip_beat2", 64'(obs_oip[2]), 64'd0);

        // 1x1 with three stall cycles
        sweep(1, 1, 1, 1, 0, 3, -1, -1);

        // zero counts
        sweep(3, 0, 0, 0, -1, 0, -1, -1);
        sweep(0, 2, 0, 0, -1, 0, -1, -1);

        // reset during second beat, then a fresh sweep with wrapping offsets
        sweep(2, 2, 4, 4, -1, 0, -1, 1);
        sweep(2, 3, 15, 31, -1, 0, -1, -1);
        chk("t6_oip_wrap", 64'(obs_oip[1]), 64'd0);
        chk("t6_owt_wrap", 64'(obs_owt[3]), 64'd0);

        // larger sweep with a mid-sweep stall and stray start
        sweep(3, 4, 9, 20, 5, 2, 7, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
